// File: rtl/ara_uart_pkg.sv
// Shared constants and types for the APB UART transmitter.
package ara_uart_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  localparam int unsigned STATUS_EMPTY     = 0;
  localparam int unsigned STATUS_FULL      = 1;
  localparam int unsigned STATUS_BUSY      = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/ara_uart_tx_fifo.sv
// Byte-wide TX FIFO; head data is presented combinationally on data_o.
module ara_uart_tx_fifo #(
  parameter int unsigned FifoDepth = 8,
  localparam int unsigned PtrW = $clog2(FifoDepth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PtrW:0] count_o
);

  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(FifoDepth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a push into a full FIFO is
  // dropped even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ara_uart_tx.sv
// APB3 completer for the UART transmit path: registers, TX FIFO, bit timer, 8N1 serialiser.
module ara_uart_tx
  import ara_uart_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned FifoDepth  = 8,
  parameter logic [15:0] DefaultDiv = 16'd433
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [DataWidth-1:0] pwdata_i,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 tx_o,
  output logic                 irq_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);

  uart_tx_state_e state_q, state_d;
  logic [15:0]    div_q;
  logic [15:0]    cnt_q, cnt_d;
  logic [7:0]     sh_q, sh_d;
  logic [2:0]     bit_q, bit_d;
  logic           tx_q, tx_d;
  logic           tx_en_q, irq_en_q;

  logic           access, mapped, wr_txdata, push, pop;
  logic [2:0]     reg_idx;
  logic [7:0]     fifo_data;
  logic           fifo_full, fifo_empty;
  logic [PtrW:0]  fifo_count;
  logic           busy, bit_end, can_start;
  logic           unused_bits;

  assign unused_bits = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0], pwdata_i[DataWidth-1:16]};

  assign access    = psel_i & penable_i;
  assign reg_idx   = paddr_i[4:2];
  assign mapped    = (reg_idx <= REG_CTRL);
  assign wr_txdata = access & pwrite_i & (reg_idx == REG_TXDATA);
  assign push      = wr_txdata & ~fifo_full;

  assign pready_o  = 1'b1;
  assign pslverr_o = access & (~mapped | (wr_txdata & fifo_full));

  assign busy  = (state_q != ST_IDLE);
  assign irq_o = irq_en_q & fifo_empty & ~busy;
  assign tx_o  = tx_q;

  ara_uart_tx_fifo #(
    .FifoDepth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pwdata_i[7:0]),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    prdata_o = '0;
    if (psel_i & ~pwrite_i) begin
      case (reg_idx)
        REG_STATUS: begin
          prdata_o[STATUS_EMPTY]            = fifo_empty;
          prdata_o[STATUS_FULL]             = fifo_full;
          prdata_o[STATUS_BUSY]             = busy;
          prdata_o[STATUS_COUNT_LSB +: 8]   = 8'(fifo_count);
        end
        REG_DIV:  prdata_o[15:0] = div_q;
        REG_CTRL: prdata_o[1:0]  = {irq_en_q, tx_en_q};
        default:  prdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= DefaultDiv;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
    end else if (access & pwrite_i) begin
      if (reg_idx == REG_DIV) div_q <= pwdata_i[15:0];
      if (reg_idx == REG_CTRL) begin
        tx_en_q  <= pwdata_i[0];
        irq_en_q <= pwdata_i[1];
      end
    end
  end

  assign bit_end   = (cnt_q == '0);
  assign can_start = ~fifo_empty & tx_en_q;

  // The timer reloads from DIV at every bit boundary, so a DIV write only
  // takes effect from the next bit onwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          state_d = ST_START;
          sh_d    = fifo_data;
          cnt_d   = div_q;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = div_q;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (can_start) begin
            pop     = 1'b1;
            state_d = ST_START;
            sh_d    = fifo_data;
            cnt_d   = div_q;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_ara_uart_tx.sv
// Scoreboard bench for ara_uart_tx: expected frames are queued on TXDATA writes and checked bit-by-bit.
module tb_ara_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, tx, irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [9:0]  exp_q [$];

  always #5 clk = ~clk;

  ara_uart_tx #(
    .AddrWidth (32),
    .DataWidth (32),
    .FifoDepth (8),
    .DefaultDiv(16'd433)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .tx_o     (tx),
    .irq_o    (irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d   = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic push_txdata(input logic [7:0] b, input logic expect_ok, output logic err);
    apb_write(32'h0, {24'h0, b}, err);
    if (expect_ok) exp_q.push_back({1'b1, b, 1'b0});
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1)      begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
    n_checks++; if (irq !== 1'b0)     begin n_fail++; $display("FAIL reset_irq: got %b, required 0", irq); end
    n_checks++; if (pready !== 1'b1)  begin n_fail++; $display("FAIL reset_pready: got %b, required 1", pready); end
    n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b, required 0", pslverr); end
    n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h, required 0", prdata); end
    apb_read(32'h4, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h, required 00000001", d); end
    apb_read(32'h8, d, e);
    n_checks++; if (d !== 32'd433) begin n_fail++; $display("FAIL reset_div: got %0d, required 433", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic [9:0]  f;
    logic        e;
    int unsigned bad = 0;
    apb_write(32'h8, 32'd3, e);
    push_txdata(8'hA5, 1'b1, e);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL frame_push_err: got %b, required 0", e); end
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_latency_t1: got %b, required 1", tx); end
    f = exp_q.pop_front();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (tx !== f[b]) bad++;
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL frame_a5_bits: got %0d wrong cycles, required 0", bad); end
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_idle_after: got %b, required 1", tx); end
    apb_read(32'h4, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL frame_status_after: got %h, required 00000001", d); end
  endtask

  task automatic test_fill_fifo();
    logic [31:0] d;
    logic        e;
    apb_write(32'h8, 32'd0, e);
    apb_write(32'hC, 32'h0, e);
    for (int i = 0; i < 9; i++) begin
      push_txdata(8'(i * 37 + 3), (i < 8), e);
      n_checks++;
      if (e !== (i == 8)) begin
        n_fail++; $display("FAIL fill_err_%0d: got %b, required %b", i, e, (i == 8));
      end
    end
    apb_read(32'h4, d, e);
    n_checks++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL fill_status: got %h, required 00000802", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [9:0]  f;
    logic        e;
    int unsigned bad = 0;
    apb_write(32'hC, 32'h1, e);
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_latency_t1: got %b, required 1", tx); end
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL b2b_queue: got empty, required frame %0d", k);
        break;
      end
      f = exp_q.pop_front();
      for (int b = 0; b < 10; b++) begin
        @(negedge clk);
        if (tx !== f[b]) bad++;
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_bits: got %0d wrong cycles, required 0", bad); end
    apb_read(32'h4, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL b2b_status: got %h, required 00000001", d); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b, required 0", irq); end
    apb_write(32'hC, 32'h3, e);
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enabled: got %b, required 1", irq); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e;
    apb_read(32'h14, d, e);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped_read_err: got %b, required 1", e); end
    apb_write(32'h14, 32'h55, e);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped_write_err: got %b, required 1", e); end
    apb_read(32'h28, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL alias_div: got %h, required 0", d); end
    apb_write(32'h4, 32'hFFFF_FFFF, e);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL status_write_err: got %b, required 0", e); end
    apb_read(32'h4, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_unchanged: got %h, required 00000001", d); end
    apb_read(32'hC, d, e);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_readback: got %h, required 00000003", d); end
    apb_read(32'h0, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h, required 0", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic        e;
    int unsigned lows = 0;
    apb_write(32'h8, 32'd3, e);
    apb_write(32'h0, 32'h00, e);
    repeat (9) @(negedge clk);
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx_low: got %b, required 0", tx); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b, required 1", tx); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    apb_read(32'h4, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL post_reset_status: got %h, required 00000001", d); end
    apb_read(32'h8, d, e);
    n_checks++; if (d !== 32'd433) begin n_fail++; $display("FAIL post_reset_div: got %0d, required 433", d); end
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL no_residual_frame: got %0d low cycles, required 0", lows); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_fifo();
    test_back_to_back();
    test_errors();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ara_uart_tx.md
# ara_uart_tx

APB3 responder implementing the transmit half of the SoC UART: the APB completer behind the SoC's `uart_*` APB initiator port. It accepts bytes through memory-mapped registers into a small FIFO and serialises them onto `tx_o` as 8N1 frames at a programmable bit period. It sits in the SoC peripheral region next to the control registers and drives the off-chip UART TX pad.

## Interface

- `AddrWidth`, 32: APB address width.
- `DataWidth`, 32: APB data width (≥ 16).
- `FifoDepth`, 8: TX FIFO entries (power of two, ≥ 2).
- `DefaultDiv`, 16'd433: reset value of DIV.

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB access phase.
- `pwrite_i` in 1: APB write.
- `paddr_i` in AddrWidth: APB address.
- `pwdata_i` in DataWidth: APB write data.
- `prdata_o` out DataWidth: APB read data.
- `pready_o` out 1: APB ready.
- `pslverr_o` out 1: APB error.
- `tx_o` out 1: serial output, idle high.
- `irq_o` out 1: TX-done interrupt.

## Operation

- Registers, decoded on `paddr_i[4:2]`; the other address bits are ignored and alias.
  - 0x00 TXDATA: a write pushes `pwdata_i[7:0]`; a read returns 0.
  - 0x04 STATUS, read-only (writes ignored, no error):
    - bit0 empty
    - bit1 full
    - bit2 busy
    - bits[15:8] FIFO count
  - 0x08 DIV: RW, 16 bits. Bit period = DIV+1 cycles.
  - 0x0C CTRL: RW.
    - bit0 tx_en, reset 1
    - bit1 irq_en, reset 0
  - 0x10–0x1C: unmapped.
- APB transfer handling:
  - `pready_o` is constant 1, so every access completes in one access-phase cycle.
  - Register and FIFO side effects happen only when `psel_i & penable_i`.
- `pslverr_o` is combinational and asserted in the access phase for:
  - any access to an unmapped address;
  - a TXDATA write while full.
  - An errored write has no side effect.
- `prdata_o` is combinational and equals the register value when `psel_i & ~pwrite_i`, otherwise 0.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when FIFO is non-empty and tx_en: pop the head, load the shift register.
  - START drives 0 for one bit period, then goes to DATA.
  - DATA drives 8 bits, LSB first, then goes to STOP.
  - STOP drives 1 for one bit period. At its end:
    - if FIFO non-empty and tx_en, pop and go directly to START (no gap);
    - otherwise go to IDLE.
- Bit timer:
  - a down-counter loaded with the current DIV at each bit start; the bit ends when it reaches 0.
  - A DIV write mid-frame affects the next bit only.
- `busy` is asserted whenever the state is not IDLE.
- `irq_o` = irq_en & empty & ~busy.
- Boundary conditions:
  - Push and pop in the same cycle: both occur; count is unchanged.
  - Push while full is rejected, even if a pop happens in the same cycle. Full is evaluated on the registered count.
  - tx_en cleared mid-frame: the current frame completes; no further pops.
  - DIV = 0 gives a 1-cycle bit.
  - `rst_i` asserted mid-frame: immediately `tx_o`=1, FIFO is emptied, FSM goes to IDLE, and registers return to their reset values. The partial frame is lost.

## Timing

- Reset values:
  - `tx_o`=1
  - `pready_o`=1
  - `pslverr_o`=0
  - `prdata_o`=0
  - `irq_o`=0
- Outputs: `tx_o` is registered; all APB outputs are combinational.
- Latency: for a TXDATA write in access cycle t while IDLE and empty, FIFO count=1 in t+1, the pop happens in t+1, and `tx_o` is low from t+2.
- Frame length: exactly 10·(DIV+1) cycles with constant DIV. Back-to-back frames have no idle cycles.
- `busy` deasserts the cycle after the STOP bit completes with the FIFO empty.

## Structure

- Package `ara_uart_pkg`:
  - register offset constants (TXDATA, STATUS, DIV, CTRL);
  - FSM state enum `uart_tx_state_e`;
  - STATUS bit index constants.
- Sub-module `ara_uart_tx_fifo` (parameter FifoDepth, byte wide):
  - ports: push, pop, data in/out, full, empty, count;
  - synchronous push/pop, asynchronous active-high reset.
- Top level contains the APB decode, the CTRL/DIV registers, the bit timer and the serialiser FSM.

## Test plan

- Reset, then read STATUS → 0x0000_0001; read DIV → 433; `tx_o`=1; `irq_o`=0.
- DIV=3, write 0xA5 → starting at t+2, `tx_o` shows 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 cycles, 40 cycles total. Then busy=0.
- DIV=0, tx_en=0, write 9 bytes → 8 writes with `pslverr_o`=0, the 9th with `pslverr_o`=1; STATUS count=8, full=1.
- Then set tx_en=1 → 8 frames of 10 cycles each, back-to-back (80 cycles, no idle high gap). Then irq_en=1 gives `irq_o`=1.
- Access to 0x14 → `pslverr_o`=1 with no side effect. Write to STATUS → no error, no change.
- Assert `rst_i` mid-DATA → `tx_o`=1 asynchronously; STATUS=0x1 after release; no residual frame follows.
